serial_chunk_adder: RTL
=======================

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-006 mode  input  1  0 = add, 1 = subtract; sampled together with start.
REQ-007 a  input  WIDTH  operand A; sampled together with start.
REQ-008 b  input  WIDTH  operand B; sampled together with start.
REQ-009 cin  input  1  carry-in (add) or borrow-in (sub); sampled together with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when the result is valid.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry-out; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Add SHALL compute a + b + cin.
REQ-016 Subtract SHALL compute a + ~b + ~cin, i.e. a - b - cin.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of bit WIDTH-1 on cout.
REQ-018 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-019 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start.
- RUN stays in RUN for exactly N cycles, then -> DONE.
- DONE -> RUN on start; otherwise DONE -> IDLE.
REQ-020 On accepting start, the block SHALL latch a, the effective B (b, or ~b when mode=1) and the initial carry (cin, or ~cin when mode=1), and SHALL clear the slice index to 0.
REQ-021 In RUN, each cycle SHALL add slice i of the latched operands plus the carry register, write CHUNK bits into sum[i*CHUNK +: CHUNK], update the carry register, and increment i; slices are processed LSB first.
REQ-022 Latency: with start accepted at edge k, the final slice SHALL be written at edge k+N, and done SHALL be high for exactly the cycle following edge k+N.
REQ-023 busy SHALL be 1 exactly while the state is RUN, and 0 in IDLE and DONE.
REQ-024 start SHALL be ignored while busy=1; latched operands and progress are unaffected.
REQ-025 start asserted during the DONE cycle SHALL be accepted (back-to-back), giving a throughput of one result per N+1 cycles.
REQ-026 sum, cout and ovf SHALL hold their last final values from the done pulse until the next accepted start.
REQ-027 After an accepted start, sum bits not yet rewritten are don't-care until done.
REQ-028 Input changes on a, b, mode or cin after start is accepted SHALL NOT affect the operation in progress.
REQ-029 With CHUNK = WIDTH (N = 1), the block SHALL complete in 1 RUN cycle with identical results.

Reset
REQ-030 While rst=1, the block SHALL asynchronously enter IDLE and set busy=0, done=0, sum=0, cout=0, ovf=0, carry register=0 and slice index=0.
REQ-031 Reset during RUN SHALL abort the operation with no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-033 Add: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; done high exactly in the cycle after edge k+4; busy high for 4 cycles.
REQ-034 Signed overflow: add a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-035 Subtract: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
REQ-035 (cont.) Subtract: a=0x8000, b=0x0001, cin=1 -> sum=0x7FFE, cout=1, ovf=1.
REQ-036 Hazards: start pulsed again at edge k+2 with new operands -> ignored, first result unchanged. start held high through the done cycle -> second operation accepted with no gap. Operands changed mid-RUN -> no effect on the result.
REQ-037 rst asserted asynchronously (between edges) at cycle k+2 -> busy, done, sum, cout and ovf all 0 immediately, state IDLE, no done pulse; the next start completes normally.
REQ-038 Random regression: 10k random {a, b, cin, mode} per parameter set (16/4, 16/16, 8/1, 32/8) -> sum, cout and ovf match a reference model; done interval = N+1.

Source files
------------

// File: rtl/serial_chunk_adder_if.sv
// rtl/serial_chunk_adder_if.sv - request/result bundle for serial_chunk_adder
`timescale 1ns/1ps
interface serial_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - add/subtract engine processing CHUNK bits per cycle, LSB slice first
`timescale 1ns/1ps
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                 clk,
  input logic                 rst,
  serial_chunk_adder_if.slave bus
);
  localparam int N      = WIDTH / CHUNK;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BASE_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDX_W-1:0] r_idx;

  logic              w_accept;
  logic              w_last;
  logic [BASE_W-1:0] w_base;
  logic [CHUNK:0]    w_slice;

  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_base   = BASE_W'(r_idx) * BASE_W'(CHUNK);
  assign w_slice  = {1'b0, r_a[w_base +: CHUNK]}
                  + {1'b0, r_b[w_base +: CHUNK]}
                  + {{CHUNK{1'b0}}, r_carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      // subtract is folded into an add of ~b with an inverted borrow-in
      r_state <= S_RUN;
      r_a     <= bus.a;
      r_b     <= bus.mode ? ~bus.b : bus.b;
      r_carry <= bus.cin ^ bus.mode;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_sum[w_base +: CHUNK] <= w_slice[CHUNK-1:0];
          r_carry                <= w_slice[CHUNK];
          if (w_last) begin
            r_state <= S_DONE;
            r_cout  <= w_slice[CHUNK];
            // carry into the MSB is a ^ b ^ sum at that bit
            r_ovf   <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice[CHUNK-1] ^ w_slice[CHUNK];
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule
